// File: rtl/mult_div_unit_if.sv
// Handshake/data bundle between the pipeline control and the MIPS multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wr_data,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wr_data,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO (IDLE -> RUN -> FIX).
// Optional MDU_FAST_MULT_EN: multiplies complete through a single-cycle multiplier.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    mult_div_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, stateNext;
    logic [CW-1:0]      count;
    logic               doneReg, divZeroReg;
    logic [WIDTH-1:0]   hiReg, loReg;

    logic               isDiv, negQ, negR, dzPend;
    logic [WIDTH-1:0]   opReg;
    logic [2*WIDTH-1:0] acc;

    logic               signedOp, divByZero, fastPath;
    logic [WIDTH-1:0]   magA, magB;
    logic [WIDTH:0]     addSum, remShift;
    logic [WIDTH-1:0]   remDiff;
    logic               remGe;
    logic [2*WIDTH-1:0] mulStep, divStep, fixResult;

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] negateIf(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    assign signedOp  = ~bus.op[0];
    assign divByZero = bus.op[1] && (bus.src_b == '0);
    assign magA      = absVal(bus.src_a, signedOp);
    assign magB      = absVal(bus.src_b, signedOp);

`ifdef MDU_FAST_MULT_EN
    logic signed [WIDTH:0]     fastA, fastB;
    logic signed [2*WIDTH+1:0] fastProd;
    assign fastA    = {signedOp & bus.src_a[WIDTH-1], bus.src_a};
    assign fastB    = {signedOp & bus.src_b[WIDTH-1], bus.src_b};
    assign fastProd = fastA * fastB;
    assign fastPath = ~bus.op[1];
`else
    assign fastPath = 1'b0;
`endif

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        addSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opReg};
        mulStep  = acc[0] ? {addSum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        remShift = acc[2*WIDTH-1:WIDTH-1];
        remGe    = (remShift >= {1'b0, opReg});
        remDiff  = remShift[WIDTH-1:0] - opReg;
        divStep  = remGe ? {remDiff, acc[WIDTH-2:0], 1'b1}
                         : {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Sign correction applied on the way into HI/LO
    always_comb begin
        if (isDiv)
            fixResult = {negateIf(acc[2*WIDTH-1:WIDTH], negR), negateIf(acc[WIDTH-1:0], negQ)};
        else
            fixResult = negQ ? (~acc + 1'b1) : acc;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (bus.start) stateNext = (divByZero || fastPath) ? FIX : RUN;
            RUN:     if (count == LAST) stateNext = FIX;
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            doneReg    <= 1'b0;
            divZeroReg <= 1'b0;
        end else begin
            state      <= stateNext;
            count      <= (state == RUN) ? count + 1'b1 : '0;
            doneReg    <= (state == FIX);
            divZeroReg <= (state == FIX) && dzPend;
        end
    end

    // Operands are captured once at launch; later changes on src_a/src_b are ignored
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            isDiv  <= bus.op[1];
            dzPend <= divByZero;
            negQ   <= signedOp & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            negR   <= signedOp & bus.src_a[WIDTH-1];
            opReg  <= bus.op[1] ? magB : magA;
            acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? magA : magB)};
`ifdef MDU_FAST_MULT_EN
            if (!bus.op[1]) begin
                acc  <= fastProd[2*WIDTH-1:0];
                negQ <= 1'b0;
            end
`endif
        end else if (state == RUN) begin
            acc <= isDiv ? divStep : mulStep;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (state == FIX) begin
            if (!dzPend) {hiReg, loReg} <= fixResult;
        end else if (state == IDLE) begin
            if (bus.hi_we) hiReg <= bus.wr_data;
            if (bus.lo_we) loReg <= bus.wr_data;
        end
    end

    assign bus.hi       = hiReg;
    assign bus.lo       = loReg;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = doneReg;
    assign bus.div_zero = divZeroReg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit (also valid with MDU_FAST_MULT_EN defined).
module tb_mult_div_unit;
    localparam int WIDTH = 32;
`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = WIDTH + 1;
`endif
    localparam int DIV_LAT = WIDTH + 1;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();
    mult_div_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[13];
    int   nVec  = 0;
    int   nFail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Launch at the next edge, scramble operands afterwards, wait (bounded) for done
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busyBad);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.src_a = ~a;
        bus.src_b = ~b;
        lat = 0;
        busyBad = 0;
        for (int k = 1; k <= 100; k++) begin
            if (bus.busy !== 1'b1) busyBad++;
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, busyBad, doneSeen;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[3]  = '{OP_DIVU,  32'd216,       32'd5,         32'd1,         32'd43,        DIV_LAT};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT};
        vecs[5]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT};
        vecs[6]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};
        vecs[7]  = '{OP_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MUL_LAT};
        vecs[8]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, DIV_LAT};
        vecs[9]  = '{OP_DIV,   32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, DIV_LAT};
        vecs[10] = '{OP_DIVU,  32'd5,         32'd216,       32'd5,         32'd0,         DIV_LAT};
        vecs[11] = '{OP_MULT,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, MUL_LAT};
        vecs[12] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, MUL_LAT};

        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);
        check("reset done", 32'(bus.done), 32'h0);
        check("reset div_zero", 32'(bus.div_zero), 32'h0);
        rst = 1'b0;

        // Back-to-back: each launch is requested in the cycle the previous done is high
        for (int i = 0; i < 13; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, lat, busyBad);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d hi", i), bus.hi, vecs[i].hi);
            check($sformatf("v%0d lo", i), bus.lo, vecs[i].lo);
            check($sformatf("v%0d div_zero", i), 32'(bus.div_zero), 32'h0);
            check($sformatf("v%0d busy at done", i), 32'(bus.busy), 32'h0);
            check($sformatf("v%0d busy gaps", i), 32'(busyBad), 32'h0);
        end

        // Preload HI/LO, then divide by zero leaves them intact
        bus.hi_we = 1'b1; bus.wr_data = 32'hAA;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wr_data = 32'h55;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        check("preload hi", bus.hi, 32'hAA);
        check("preload lo", bus.lo, 32'h55);
        runOp(OP_DIV, 32'd9, 32'd0, lat, busyBad);
        check("div0 latency", 32'(lat), 32'd1);
        check("div0 flag", 32'(bus.div_zero), 32'h1);
        check("div0 busy", 32'(bus.busy), 32'h0);
        check("div0 hi", bus.hi, 32'hAA);
        check("div0 lo", bus.lo, 32'h55);
        @(posedge clk); #1;
        check("div0 done pulse", 32'(bus.done), 32'h0);
        check("div0 flag pulse", 32'(bus.div_zero), 32'h0);

        // Reset mid-operation, with an ignored second start in flight
        bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = OP_MULT; bus.src_a = 32'd5; bus.src_b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("restart ignored busy", 32'(bus.busy), 32'h1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort hi", bus.hi, 32'h0);
        check("abort lo", bus.lo, 32'h0);
        check("abort busy", 32'(bus.busy), 32'h0);
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) doneSeen++;
        end
        check("abort no done", 32'(doneSeen), 32'h0);

        // MT writes in IDLE, both at once, and ignored while busy
        bus.hi_we = 1'b1; bus.wr_data = 32'h1234_5678;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        check("mthi", bus.hi, 32'h1234_5678);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'hCAFE_BABE;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("mthi+mtlo hi", bus.hi, 32'hCAFE_BABE);
        check("mthi+mtlo lo", bus.lo, 32'hCAFE_BABE);

        bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd17; bus.src_b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.hi_we = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        check("mthi while busy", bus.hi, 32'hCAFE_BABE);
        lat = 0;
        for (int k = 2; k <= 100; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("busy-write op latency", 32'(lat), 32'(DIV_LAT));
        check("busy-write op hi", bus.hi, 32'd2);
        check("busy-write op lo", bus.lo, 32'd3);

        // MT write on the launch edge lands first, the result overwrites it
        bus.hi_we = 1'b1; bus.wr_data = 32'h77;
        bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd20; bus.src_b = 32'd6;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.start = 1'b0;
        check("mt at launch", bus.hi, 32'h77);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("mt-launch op latency", 32'(lat), 32'(DIV_LAT));
        check("mt-launch op hi", bus.hi, 32'd2);
        check("mt-launch op lo", bus.lo, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
